// File: rtl/uart_tx_arbiter_if.sv
// -----------------------------------------------------------------------------
// uart_tx_arbiter_if
// Bundles the requester-side byte streams and the TX FIFO write port used by
// uart_tx_arbiter.
//   req_valid_i  [NUM_REQ]             per-requester byte valid
//   req_data_i   [NUM_REQ*DATA_WIDTH]  packed bytes, requester k at [k*DATA_WIDTH +: DATA_WIDTH]
//   req_last_i   [NUM_REQ]             last byte of a requester's packet
//   req_ready_o  [NUM_REQ]             per-requester accept strobe
//   fifo_full_i                        TX FIFO full
//   fifo_wr_en_o                       TX FIFO write strobe
//   fifo_data_o  [DATA_WIDTH]          TX FIFO write data
// Modports: master = requesters/FIFO side (drives the *_i signals),
//           slave  = arbiter (drives the *_o signals).
// -----------------------------------------------------------------------------
interface uart_tx_arbiter_if #(
    parameter int NUM_REQ    = 4,
    parameter int DATA_WIDTH = 8
);
    logic [NUM_REQ-1:0]            req_valid_i;
    logic [NUM_REQ*DATA_WIDTH-1:0] req_data_i;
    logic [NUM_REQ-1:0]            req_last_i;
    logic [NUM_REQ-1:0]            req_ready_o;
    logic                          fifo_full_i;
    logic                          fifo_wr_en_o;
    logic [DATA_WIDTH-1:0]         fifo_data_o;

    modport master (
        output req_valid_i, req_data_i, req_last_i, fifo_full_i,
        input  req_ready_o, fifo_wr_en_o, fifo_data_o
    );

    modport slave (
        input  req_valid_i, req_data_i, req_last_i, fifo_full_i,
        output req_ready_o, fifo_wr_en_o, fifo_data_o
    );
endinterface

// File: rtl/uart_tx_arbiter.sv
// -----------------------------------------------------------------------------
// uart_tx_arbiter
// Grants one of NUM_REQ byte streams at a time access to a shared UART TX
// FIFO. A grant lasts until the owner sends its last byte, MAX_BURST bytes
// have been written, or the owner stalls for TIMEOUT_CYCLES cycles. Every
// release is followed by at least one IDLE cycle before the next grant.
//
// Ports
//   pclk_i        clock, rising edge
//   presetn_i     asynchronous active-low reset
//   arb_enable_i  permits new grants from IDLE (never aborts a burst)
//   bus           uart_tx_arbiter_if.slave: requester streams + FIFO write port
//   grant_o       one-hot current owner, zero when none
//   busy_o        high while a burst is in progress
//   timeout_o     one-cycle pulse after a stalled grant is revoked
//
// Build option
//   UART_TX_ARB_PRIO_EN  when defined, requester 0 wins every IDLE
//                        arbitration it takes part in; the others keep
//                        rotating round-robin. Undefined: pure round-robin.
// -----------------------------------------------------------------------------
module uart_tx_arbiter #(
    parameter int NUM_REQ        = 4,
    parameter int DATA_WIDTH     = 8,
    parameter int MAX_BURST      = 16,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic               pclk_i,
    input  logic               presetn_i,
    input  logic               arb_enable_i,
    uart_tx_arbiter_if.slave   bus,
    output logic [NUM_REQ-1:0] grant_o,
    output logic               busy_o,
    output logic               timeout_o
);

    localparam int IDX_W  = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int BCNT_W = $clog2(MAX_BURST) + 1;
    localparam int ICNT_W = $clog2(TIMEOUT_CYCLES + 1);

    typedef enum logic {S_IDLE, S_BURST} state_t;

    state_t                r_state;
    logic [NUM_REQ-1:0]    r_grant;
    logic                  r_busy;
    logic                  r_timeout;
    logic [IDX_W-1:0]      r_owner;
    logic [IDX_W-1:0]      r_last_owner;
    logic [BCNT_W-1:0]     r_burst_cnt;
    logic [ICNT_W-1:0]     r_idle_cnt;

    logic [NUM_REQ-1:0]    w_ready;
    logic                  w_owner_valid;
    logic                  w_owner_last;
    logic [DATA_WIDTH-1:0] w_owner_byte;
    logic                  w_xfer;
    logic                  w_release;
    logic                  w_found;
    logic [IDX_W-1:0]      w_win;
    logic [IDX_W-1:0]      w_idx;

    // Owner-side view of the request bus. A compare-per-requester mux keeps
    // the indexing constant, which also covers non power-of-two NUM_REQ.
    always_comb begin
        w_ready       = '0;
        w_owner_valid = 1'b0;
        w_owner_last  = 1'b0;
        w_owner_byte  = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (r_owner == IDX_W'(k)) begin
                w_ready[k]    = (r_state == S_BURST) && !bus.fifo_full_i;
                w_owner_valid = bus.req_valid_i[k];
                w_owner_last  = bus.req_last_i[k];
                w_owner_byte  = bus.req_data_i[k*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    assign w_xfer = (r_state == S_BURST) && w_owner_valid && !bus.fifo_full_i;

    // The transfer that completes the packet or fills the burst ends the grant.
    assign w_release = w_xfer &&
                       (w_owner_last || (r_burst_cnt == BCNT_W'(MAX_BURST - 1)));

    assign bus.req_ready_o  = w_ready;
    assign bus.fifo_wr_en_o = w_xfer;
    assign bus.fifo_data_o  = w_xfer ? w_owner_byte : '0;

    // Round-robin search starting just after the previous owner.
    always_comb begin
        w_found = 1'b0;
        w_win   = '0;
        w_idx   = '0;
        for (int i = 1; i <= NUM_REQ; i++) begin
            w_idx = IDX_W'((int'(r_last_owner) + i) % NUM_REQ);
            if (!w_found && bus.req_valid_i[w_idx]) begin
                w_found = 1'b1;
                w_win   = w_idx;
            end
        end
`ifdef UART_TX_ARB_PRIO_EN
        // Requester 0 overrides the rotation whenever it is asking.
        if (bus.req_valid_i[0]) begin
            w_found = 1'b1;
            w_win   = '0;
        end
`endif
    end

    always_ff @(posedge pclk_i or negedge presetn_i) begin
        if (!presetn_i) begin
            r_state      <= S_IDLE;
            r_grant      <= '0;
            r_busy       <= 1'b0;
            r_timeout    <= 1'b0;
            r_owner      <= '0;
            r_last_owner <= IDX_W'(NUM_REQ - 1);
            r_burst_cnt  <= '0;
            r_idle_cnt   <= '0;
        end else begin
            r_timeout <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (arb_enable_i && w_found) begin
                        r_state     <= S_BURST;
                        r_busy      <= 1'b1;
                        r_owner     <= w_win;
                        r_grant     <= NUM_REQ'(1) << w_win;
                        r_burst_cnt <= '0;
                        r_idle_cnt  <= '0;
                    end
                end
                S_BURST: begin
                    if (w_xfer) begin
                        r_burst_cnt <= r_burst_cnt + 1'b1;
                        r_idle_cnt  <= '0;
                        if (w_release) begin
                            r_state      <= S_IDLE;
                            r_busy       <= 1'b0;
                            r_grant      <= '0;
                            r_last_owner <= r_owner;
                        end
                    end else begin
                        // Stall cycles (owner not valid or FIFO full) both count.
                        r_idle_cnt <= r_idle_cnt + 1'b1;
                        if (r_idle_cnt == ICNT_W'(TIMEOUT_CYCLES - 1)) begin
                            r_state      <= S_IDLE;
                            r_busy       <= 1'b0;
                            r_grant      <= '0;
                            r_last_owner <= r_owner;
                            r_timeout    <= 1'b1;
                        end
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    r_busy  <= 1'b0;
                    r_grant <= '0;
                end
            endcase
        end
    end

    assign grant_o   = r_grant;
    assign busy_o    = r_busy;
    assign timeout_o = r_timeout;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
module tb_uart_tx_arbiter;
    localparam int NR   = 4;
    localparam int DW   = 8;
    localparam int MAXB = 16;
    localparam int TMO  = 10;

    logic          pclk;
    logic          presetn;
    logic          arb_en;
    logic [NR-1:0] grant;
    logic          busy;
    logic          tmo;

    uart_tx_arbiter_if #(.NUM_REQ(NR), .DATA_WIDTH(DW)) bus ();

    uart_tx_arbiter #(
        .NUM_REQ(NR), .DATA_WIDTH(DW), .MAX_BURST(MAXB), .TIMEOUT_CYCLES(TMO)
    ) dut (
        .pclk_i(pclk), .presetn_i(presetn), .arb_enable_i(arb_en), .bus(bus),
        .grant_o(grant), .busy_o(busy), .timeout_o(tmo)
    );

    initial pclk = 1'b0;
    always #5 pclk = ~pclk;

    int n_cmp = 0;
    int n_fail = 0;

    // Requester sources: each entry is {last, byte}
    logic [8:0] srcq [NR][$];
    bit         hold [NR];
    bit         full;

    // Reference model: who owns the FIFO (-1 = nobody), rotation pointer,
    // bytes in this grant, stalled cycles, pending timeout pulse.
    int m_owner, m_last, m_cnt, m_idle;
    bit m_tmo;

    // Output vector {grant[4], busy, timeout, ready[4], wr_en, data[8]}
    logic [18:0]   exp_vec, act_vec;
    logic [NR-1:0] prev_grant;
    int            gseq[$];
    int            bcount[$];
    logic [7:0]    alog[$];
    int            tmo_cnt;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, want completion");
        $fatal(1);
    end

    function automatic int pick(input logic [NR-1:0] v);
`ifdef UART_TX_ARB_PRIO_EN
        if (v[0]) return 0;
`endif
        for (int i = 1; i <= NR; i++)
            if (v[(m_last + i) % NR]) return (m_last + i) % NR;
        return -1;
    endfunction

    function automatic int bytes_left();
        int n = 0;
        for (int k = 0; k < NR; k++) n += srcq[k].size();
        return n;
    endfunction

    function automatic int onehot_idx(input logic [NR-1:0] g);
        if ($countones(g) != 1) return 99;
        for (int k = 0; k < NR; k++) if (g[k]) return k;
        return 99;
    endfunction

    task automatic model_reset();
        m_owner = -1; m_last = NR - 1; m_cnt = 0; m_idle = 0; m_tmo = 1'b0;
        prev_grant = '0;
    endtask

    task automatic push_pkt(input int k, input int n);
        for (int i = 0; i < n; i++)
            srcq[k].push_back({(i == n - 1), 8'($urandom)});
    endtask

    task automatic clear_logs();
        gseq.delete(); bcount.delete(); alog.delete(); tmo_cnt = 0;
    endtask

    // One clock: drive inputs, predict and sample outputs at negedge, advance model.
    task automatic cycle();
        logic [NR-1:0]    v, l, eg, er;
        logic [NR*DW-1:0] d;
        logic [7:0]       b;
        logic [8:0]       popped;
        int               g;
        bit               wr;
        v = '0; l = '0; d = '0;
        for (int k = 0; k < NR; k++)
            if (srcq[k].size() > 0 && !hold[k]) begin
                v[k] = 1'b1;
                l[k] = srcq[k][0][8];
                d[k*DW +: DW] = srcq[k][0][7:0];
            end
        bus.req_valid_i = v; bus.req_last_i = l; bus.req_data_i = d; bus.fifo_full_i = full;
        @(negedge pclk);
        g = m_owner; wr = 1'b0; b = '0; eg = '0; er = '0;
        if (g >= 0) begin
            eg[g] = 1'b1;
            er[g] = !full;
            wr    = v[g] && !full;
            if (wr) b = d[g*DW +: DW];
        end
        exp_vec = {eg, (g >= 0), m_tmo, er, wr, b};
        act_vec = {grant, busy, tmo, bus.req_ready_o, bus.fifo_wr_en_o, bus.fifo_data_o};
        if (grant != '0 && prev_grant == '0) begin
            gseq.push_back(onehot_idx(grant));
            bcount.push_back(0);
        end
        prev_grant = grant;
        if (bus.fifo_wr_en_o) begin
            alog.push_back(bus.fifo_data_o);
            if (bcount.size() > 0) bcount[bcount.size() - 1] += 1;
        end
        if (tmo) tmo_cnt++;
        m_tmo = 1'b0;
        if (g < 0) begin
            if (arb_en && v != '0) begin
                m_owner = pick(v); m_cnt = 0; m_idle = 0;
            end
        end else if (wr) begin
            popped = srcq[g].pop_front();
            m_cnt++; m_idle = 0;
            if (popped[8] || m_cnt == MAXB) begin m_last = g; m_owner = -1; end
        end else begin
            m_idle++;
            if (m_idle == TMO) begin m_last = g; m_owner = -1; m_tmo = 1'b1; end
        end
        @(posedge pclk); #1;
    endtask

    task automatic test_reset();
        presetn = 1'b1; arb_en = 1'b0; full = 1'b0;
        bus.req_valid_i = '0; bus.req_last_i = '0; bus.req_data_i = '0; bus.fifo_full_i = 1'b0;
        for (int k = 0; k < NR; k++) hold[k] = 1'b0;
        #1 presetn = 1'b0;
        #2;
        act_vec = {grant, busy, tmo, bus.req_ready_o, bus.fifo_wr_en_o, bus.fifo_data_o};
        n_cmp++;
        if (act_vec !== '0) begin
            n_fail++; $display("FAIL reset_outputs: got %h want 0", act_vec);
        end
        model_reset();
        @(posedge pclk); #1;
        presetn = 1'b1; arb_en = 1'b1;
    endtask

    task automatic test_round_robin();
        int e[5];
        int got;
`ifdef UART_TX_ARB_PRIO_EN
        e = '{0, 0, 1, 2, 3};
`else
        e = '{0, 1, 2, 3, 0};
`endif
        for (int k = 0; k < NR; k++) begin push_pkt(k, 1); push_pkt(k, 1); end
        clear_logs();
        for (int c = 0; c < 60 && !(bytes_left() == 0 && m_owner < 0); c++) begin
            cycle(); n_cmp++;
            if (act_vec !== exp_vec) begin
                n_fail++; $display("FAIL rr_cycle: got %h want %h", act_vec, exp_vec);
            end
        end
        n_cmp++;
        if (bytes_left() != 0) begin
            n_fail++; $display("FAIL rr_drain: bytes left %0d want 0", bytes_left());
        end
        for (int i = 0; i < 5; i++) begin
            got = (i < gseq.size()) ? gseq[i] : -1;
            n_cmp++;
            if (got != e[i]) begin
                n_fail++; $display("FAIL rr_order[%0d]: got %0d want %0d", i, got, e[i]);
            end
        end
    endtask

    task automatic test_max_burst();
        int eb[2];
        int got_b, got_g;
        eb = '{MAXB, 20 - MAXB};
        push_pkt(2, 20);
        clear_logs();
        for (int c = 0; c < 80 && !(bytes_left() == 0 && m_owner < 0); c++) begin
            cycle(); n_cmp++;
            if (act_vec !== exp_vec) begin
                n_fail++; $display("FAIL burst_cycle: got %h want %h", act_vec, exp_vec);
            end
        end
        n_cmp++;
        if (gseq.size() != 2) begin
            n_fail++; $display("FAIL burst_grants: got %0d want 2", gseq.size());
        end
        for (int i = 0; i < 2; i++) begin
            got_b = (i < bcount.size()) ? bcount[i] : -1;
            got_g = (i < gseq.size()) ? gseq[i] : -1;
            n_cmp++;
            if (got_b != eb[i] || got_g != 2) begin
                n_fail++;
                $display("FAIL burst_len[%0d]: got owner %0d len %0d want owner 2 len %0d",
                         i, got_g, got_b, eb[i]);
            end
        end
    endtask

    task automatic test_fifo_full();
        logic [8:0] sent[$];
        push_pkt(1, 8);
        sent = srcq[1];
        clear_logs();
        for (int c = 0; c < 60 && !(bytes_left() == 0 && m_owner < 0); c++) begin
            full = (c >= 3 && c < 8);
            cycle(); n_cmp++;
            if (act_vec !== exp_vec) begin
                n_fail++; $display("FAIL full_cycle: got %h want %h", act_vec, exp_vec);
            end
            if (full) begin
                n_cmp++;
                if (act_vec[12:8] !== 5'b0) begin
                    n_fail++; $display("FAIL full_stall: ready/wr got %b want 00000", act_vec[12:8]);
                end
            end
        end
        full = 1'b0;
        n_cmp++;
        if (alog.size() != sent.size()) begin
            n_fail++; $display("FAIL full_count: got %0d bytes want %0d", alog.size(), sent.size());
        end
        for (int i = 0; i < sent.size() && i < alog.size(); i++) begin
            n_cmp++;
            if (alog[i] !== sent[i][7:0]) begin
                n_fail++; $display("FAIL full_byte[%0d]: got %h want %h", i, alog[i], sent[i][7:0]);
            end
        end
    endtask

    task automatic test_timeout();
        int g0, g1;
        push_pkt(3, 4);
        push_pkt(1, 1);
        clear_logs();
        for (int c = 0; c < 40; c++) begin
            if (srcq[3].size() == 2) hold[3] = 1'b1;
            cycle(); n_cmp++;
            if (act_vec !== exp_vec) begin
                n_fail++; $display("FAIL tmo_cycle: got %h want %h", act_vec, exp_vec);
            end
        end
        g0 = (gseq.size() > 0) ? gseq[0] : -1;
        g1 = (gseq.size() > 1) ? gseq[1] : -1;
        n_cmp++;
        if (tmo_cnt != 1) begin
            n_fail++; $display("FAIL tmo_pulses: got %0d want 1", tmo_cnt);
        end
        n_cmp++;
        if (g0 != 3 || g1 != 1) begin
            n_fail++; $display("FAIL tmo_next: got %0d,%0d want 3,1", g0, g1);
        end
        hold[3] = 1'b0;
        for (int c = 0; c < 40 && !(bytes_left() == 0 && m_owner < 0); c++) begin
            cycle(); n_cmp++;
            if (act_vec !== exp_vec) begin
                n_fail++; $display("FAIL tmo_drain_cycle: got %h want %h", act_vec, exp_vec);
            end
        end
    endtask

    task automatic test_prio();
        int want, got;
`ifdef UART_TX_ARB_PRIO_EN
        want = 0;
`else
        want = 1;
`endif
        push_pkt(0, 1);
        for (int c = 0; c < 10 && !(bytes_left() == 0 && m_owner < 0); c++) begin
            cycle(); n_cmp++;
            if (act_vec !== exp_vec) begin
                n_fail++; $display("FAIL prio_setup: got %h want %h", act_vec, exp_vec);
            end
        end
        push_pkt(0, 1);
        push_pkt(1, 1);
        clear_logs();
        for (int c = 0; c < 20 && !(bytes_left() == 0 && m_owner < 0); c++) begin
            cycle(); n_cmp++;
            if (act_vec !== exp_vec) begin
                n_fail++; $display("FAIL prio_cycle: got %h want %h", act_vec, exp_vec);
            end
        end
        got = (gseq.size() > 0) ? gseq[0] : -1;
        n_cmp++;
        if (got != want) begin
            n_fail++; $display("FAIL prio_winner: got %0d want %0d", got, want);
        end
    endtask

    task automatic test_reset_mid();
        int got;
        push_pkt(2, 6);
        for (int c = 0; c < 20 && srcq[2].size() > 3; c++) begin
            cycle(); n_cmp++;
            if (act_vec !== exp_vec) begin
                n_fail++; $display("FAIL rstmid_cycle: got %h want %h", act_vec, exp_vec);
            end
        end
        n_cmp++;
        if (srcq[2].size() != 3 || m_owner != 2) begin
            n_fail++; $display("FAIL rstmid_setup: left %0d owner %0d want 3 and 2", srcq[2].size(), m_owner);
        end
        push_pkt(1, 2);
        push_pkt(3, 2);
        #2 presetn = 1'b0;
        #1;
        act_vec = {grant, busy, tmo, bus.req_ready_o, bus.fifo_wr_en_o, bus.fifo_data_o};
        n_cmp++;
        if (act_vec !== '0) begin
            n_fail++; $display("FAIL rstmid_async: got %h want 0", act_vec);
        end
        @(posedge pclk); #1;
        model_reset();
        presetn = 1'b1;
        clear_logs();
        for (int c = 0; c < 60 && !(bytes_left() == 0 && m_owner < 0); c++) begin
            cycle(); n_cmp++;
            if (act_vec !== exp_vec) begin
                n_fail++; $display("FAIL rstmid_cycle2: got %h want %h", act_vec, exp_vec);
            end
        end
        got = (gseq.size() > 0) ? gseq[0] : -1;
        n_cmp++;
        if (got != 1) begin
            n_fail++; $display("FAIL rstmid_first: got %0d want 1", got);
        end
    endtask

    task automatic test_random();
        for (int c = 0; c < 600; c++) begin
            arb_en = ($urandom_range(0, 7) != 0);
            full   = ($urandom_range(0, 4) == 0);
            if ($urandom_range(0, 15) == 0) begin
                int hk;
                hk = $urandom_range(0, NR - 1);
                hold[hk] = !hold[hk];
            end
            for (int k = 0; k < NR; k++)
                if (srcq[k].size() == 0 && $urandom_range(0, 7) == 0)
                    push_pkt(k, $urandom_range(1, 20));
            cycle(); n_cmp++;
            if (act_vec !== exp_vec) begin
                n_fail++; $display("FAIL rand_cycle %0d: got %h want %h", c, act_vec, exp_vec);
            end
        end
        arb_en = 1'b1; full = 1'b0;
        for (int k = 0; k < NR; k++) hold[k] = 1'b0;
        for (int c = 0; c < 400 && !(bytes_left() == 0 && m_owner < 0); c++) begin
            cycle(); n_cmp++;
            if (act_vec !== exp_vec) begin
                n_fail++; $display("FAIL rand_drain_cycle: got %h want %h", act_vec, exp_vec);
            end
        end
        n_cmp++;
        if (bytes_left() != 0) begin
            n_fail++; $display("FAIL rand_drain: bytes left %0d want 0", bytes_left());
        end
    endtask

    initial begin
        test_reset();
        test_round_robin();
        test_max_burst();
        test_fifo_full();
        test_timeout();
        test_prio();
        test_reset_mid();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule

// File: doc/uart_tx_arbiter.md
UART_TX_ARBITER -- requirements
Module: uart_tx_arbiter

Interface
REQ-001 Parameter NUM_REQ, default 4, SHALL set the number of requesters (range 2..8).
REQ-002 Parameter DATA_WIDTH, default 8, SHALL set the byte width per requester.
REQ-003 Parameter MAX_BURST, default 16, SHALL set the maximum bytes per grant (range 1..256).
REQ-004 Parameter TIMEOUT_CYCLES, default 255, SHALL set the idle cycles before a stalled grant is revoked (range 1..255).
REQ-005 pclk_i  input  1  clock; all logic SHALL be on the rising edge.
REQ-006 presetn_i  input  1  reset; SHALL be asynchronous and active-low.
REQ-007 arb_enable_i  input  1  permits new grants.
REQ-008 req_valid_i  input  NUM_REQ  per-requester byte valid.
REQ-009 req_data_i  input  NUM_REQ*DATA_WIDTH  packed bytes; requester k SHALL occupy bits [k*DATA_WIDTH +: DATA_WIDTH].
REQ-010 req_last_i  input  NUM_REQ  marks the last byte of a requester's packet.
REQ-011 req_ready_o  output  NUM_REQ  per-requester accept strobe.
REQ-012 fifo_full_i  input  1  TX FIFO full.
REQ-013 fifo_wr_en_o  output  1  TX FIFO write strobe.
REQ-014 fifo_data_o  output  DATA_WIDTH  TX FIFO write data.
REQ-015 grant_o  output  NUM_REQ  one-hot current owner; all zeros when none.
REQ-016 busy_o  output  1  high while in BURST.
REQ-017 timeout_o  output  1  one-cycle pulse when a grant is revoked.

Function
REQ-018 The FSM SHALL have two states: IDLE and BURST.
REQ-019 In IDLE with arb_enable_i=1 and any req_valid_i bit set, the block SHALL register a winner into grant_o and enter BURST on the next edge. Latency from valid to grant SHALL be 1 cycle.
REQ-020 The winner SHALL be selected round-robin: search starts at index (last_owner+1) mod NUM_REQ. last_owner resets to NUM_REQ-1, so requester 0 wins first.
REQ-021 In BURST, req_ready_o[g] SHALL equal !fifo_full_i combinationally for the owner g. All other ready bits SHALL be 0, and all ready bits SHALL be 0 in IDLE.
REQ-022 A transfer occurs when req_valid_i[g] && req_ready_o[g]. In that cycle fifo_wr_en_o SHALL be 1 and fifo_data_o SHALL carry requester g's byte. Otherwise fifo_wr_en_o SHALL be 0.
REQ-023 The burst counter (width $clog2(MAX_BURST)+1) SHALL clear on grant and increment by one per transfer.
REQ-024 A transfer with req_last_i[g]=1, or the transfer that makes the count equal MAX_BURST, SHALL release the grant. On release: last_owner<=g, grant_o<=0, state<=IDLE on the next edge.
REQ-025 The idle counter SHALL clear on every transfer and on grant. It SHALL increment on each BURST cycle without a transfer, including cycles where fifo_full_i=1.
REQ-026 When the idle counter reaches TIMEOUT_CYCLES, the block SHALL release as in REQ-024 and assert timeout_o for exactly that release cycle+1.
REQ-027 Deasserting arb_enable_i SHALL NOT abort a burst in progress. It SHALL only block grants made from IDLE.
REQ-028 After each release the block SHALL spend at least one cycle in IDLE; there SHALL be no back-to-back grant in the same cycle.
REQ-029 If requester g deasserts valid mid-packet, the grant SHALL be held, subject to REQ-026.

Reset
REQ-030 On presetn_i=0 the block SHALL immediately force the following, regardless of the current state, including mid-burst:
- state=IDLE
- grant_o=0, busy_o=0, timeout_o=0
- fifo_wr_en_o=0, fifo_data_o=0, req_ready_o=0
- both counters=0
- last_owner=NUM_REQ-1

Configuration
REQ-031 With macro UART_TX_ARB_PRIO_EN defined, requester 0 SHALL win any IDLE arbitration in which req_valid_i[0]=1, regardless of the round-robin pointer. Other requesters SHALL still rotate among themselves.
REQ-032 With UART_TX_ARB_PRIO_EN undefined, arbitration SHALL be pure round-robin per REQ-020.

Verification
REQ-033 Reset, then req_valid_i=4'b1111, all last=1 -> grants 0,1,2,3,0 in order, one byte each, with one IDLE cycle between grants.
REQ-034 Requester 2 sends 20 bytes with last only on byte 20, MAX_BURST=16 -> release after 16 transfers, then re-grant to requester 2 (sole requester) for the remaining 4.
REQ-035 During a burst, fifo_full_i=1 for 5 cycles -> ready=0 and wr_en=0 for those 5 cycles, no byte lost or duplicated, idle counter reaches 5 then clears on the next transfer.
REQ-036 Owner drops valid for TIMEOUT_CYCLES=10 cycles -> timeout_o pulses once, grant_o=0, next requester is granted.
REQ-037 With UART_TX_ARB_PRIO_EN defined, last_owner=0 and valid=4'b0011 -> requester 0 is granted, not 1. Without the macro -> requester 1 is granted.
REQ-038 presetn_i asserted mid-burst after 3 bytes -> all outputs 0 asynchronously, and the first post-reset grant goes to the lowest-index valid requester.
